data_mem_controller: RTL



---
 rtl/data_mem_controller_if.sv | 45 ++++
 rtl/data_mem_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller_if.sv
// Data-memory request bundle: per-lane LSU request/ack signals plus the
// per-channel external memory request/ack signals. slave = controller side.
interface data_mem_controller_if #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4
);
    logic [NUM_CONSUMERS-1:0] consumer_read_valid;
    logic [NUM_CONSUMERS-1:0] consumer_write_valid;
    logic [ADDR_WIDTH-1:0]    consumer_addr       [NUM_CONSUMERS];
    logic [DATA_WIDTH-1:0]    consumer_write_data [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_read_ready;
    logic [NUM_CONSUMERS-1:0] consumer_write_ready;
    logic [DATA_WIDTH-1:0]    consumer_read_data  [NUM_CONSUMERS];

    logic [NUM_CHANNELS-1:0]  mem_read_valid;
    logic [ADDR_WIDTH-1:0]    mem_read_addr   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_read_ready;
    logic [DATA_WIDTH-1:0]    mem_read_data   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_write_valid;
    logic [ADDR_WIDTH-1:0]    mem_write_addr  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    mem_write_data  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_write_valid,
        input  consumer_addr, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_write_ready,
        output consumer_read_data,
        output mem_read_valid, mem_read_addr,
        output mem_write_valid, mem_write_addr, mem_write_data
    );

    modport master (
        output consumer_read_valid, consumer_write_valid,
        output consumer_addr, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_write_ready,
        input  consumer_read_data,
        input  mem_read_valid, mem_read_addr,
        input  mem_write_valid, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/data_mem_controller.sv
// Funnels per-lane load/store requests onto NUM_CHANNELS memory channels.
// Ports: clk, rst (sync, active-high), bus (data_mem_controller_if.slave).
module data_mem_controller #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4
) (
    input logic clk,
    input logic rst,
    data_mem_controller_if.slave bus
);
    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_READ_RELAY,
        S_WRITE_WAIT,
        S_WRITE_RELAY
    } state_e;

    state_e                   state_q [NUM_CHANNELS];
    state_e                   state_d [NUM_CHANNELS];
    logic [IW-1:0]            idx_q   [NUM_CHANNELS];
    logic [IW-1:0]            idx_d   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] taken_q, taken_d;

    logic [NUM_CHANNELS-1:0]  rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]    rd_addr_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  wr_vld_q, wr_vld_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]    wr_addr_d [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    wr_data_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    wr_data_d [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] c_rrdy_q, c_rrdy_d;
    logic [NUM_CONSUMERS-1:0] c_wrdy_q, c_wrdy_d;
    logic [DATA_WIDTH-1:0]    c_rdata_q [NUM_CONSUMERS];
    logic [DATA_WIDTH-1:0]    c_rdata_d [NUM_CONSUMERS];

    // Lanes claimed earlier in this cycle by lower-numbered channels
    logic [NUM_CONSUMERS-1:0] claimed;
    logic                     found;
    logic [IW-1:0]            sel;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        taken_d   = taken_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        wr_vld_d  = wr_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        c_rrdy_d  = c_rrdy_q;
        c_wrdy_d  = c_wrdy_q;
        c_rdata_d = c_rdata_q;
        claimed   = '0;
        found     = 1'b0;
        sel       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                S_IDLE: begin
                    found = 1'b0;
                    sel   = '0;
                    for (int l = 0; l < NUM_CONSUMERS; l++) begin
                        if (!found && !taken_q[l] && !claimed[l] &&
                            (bus.consumer_read_valid[l] ||
                             bus.consumer_write_valid[l])) begin
                            found = 1'b1;
                            sel   = IW'(l);
                        end
                    end
                    if (found) begin
                        claimed[sel] = 1'b1;
                        taken_d[sel] = 1'b1;
                        idx_d[c]     = sel;
                        // Read wins; a pending write is re-arbitrated later
                        if (bus.consumer_read_valid[sel]) begin
                            rd_vld_d[c]  = 1'b1;
                            rd_addr_d[c] = bus.consumer_addr[sel];
                            state_d[c]   = S_READ_WAIT;
                        end else begin
                            wr_vld_d[c]  = 1'b1;
                            wr_addr_d[c] = bus.consumer_addr[sel];
                            wr_data_d[c] = bus.consumer_write_data[sel];
                            state_d[c]   = S_WRITE_WAIT;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (bus.mem_read_ready[c]) begin
                        rd_vld_d[c]          = 1'b0;
                        c_rrdy_d[idx_q[c]]   = 1'b1;
                        c_rdata_d[idx_q[c]]  = bus.mem_read_data[c];
                        state_d[c]           = S_READ_RELAY;
                    end
                end
                S_READ_RELAY: begin
                    if (!bus.consumer_read_valid[idx_q[c]]) begin
                        c_rrdy_d[idx_q[c]] = 1'b0;
                        taken_d[idx_q[c]]  = 1'b0;
                        state_d[c]         = S_IDLE;
                    end
                end
                S_WRITE_WAIT: begin
                    if (bus.mem_write_ready[c]) begin
                        wr_vld_d[c]        = 1'b0;
                        c_wrdy_d[idx_q[c]] = 1'b1;
                        state_d[c]         = S_WRITE_RELAY;
                    end
                end
                S_WRITE_RELAY: begin
                    if (!bus.consumer_write_valid[idx_q[c]]) begin
                        c_wrdy_d[idx_q[c]] = 1'b0;
                        taken_d[idx_q[c]]  = 1'b0;
                        state_d[c]         = S_IDLE;
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '{default: S_IDLE};
            idx_q     <= '{default: '0};
            taken_q   <= '0;
            rd_vld_q  <= '0;
            rd_addr_q <= '{default: '0};
            wr_vld_q  <= '0;
            wr_addr_q <= '{default: '0};
            wr_data_q <= '{default: '0};
            c_rrdy_q  <= '0;
            c_wrdy_q  <= '0;
            c_rdata_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            taken_q   <= taken_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            c_rrdy_q  <= c_rrdy_d;
            c_wrdy_q  <= c_wrdy_d;
            c_rdata_q <= c_rdata_d;
        end
    end

    assign bus.mem_read_valid       = rd_vld_q;
    assign bus.mem_read_addr        = rd_addr_q;
    assign bus.mem_write_valid      = wr_vld_q;
    assign bus.mem_write_addr       = wr_addr_q;
    assign bus.mem_write_data       = wr_data_q;
    assign bus.consumer_read_ready  = c_rrdy_q;
    assign bus.consumer_write_ready = c_wrdy_q;
    assign bus.consumer_read_data   = c_rdata_q;
endmodule
